miss_burst_controller: RTL and testbench

- Parametrised successor of the single-cycle miss FSM that sits between the cache and main memory.
- Accepts a miss from the cache and, when the victim is dirty, writes it back as a word-serial burst.
- Refills the line as a word-serial burst over a valid/ready memory request channel with in-order read responses, then returns the assembled block to the cache.
- Line size, word width and address width are generic; memory latency and back-pressure are arbitrary.

---
 rtl/miss_burst_controller.sv | 134 +++++++++++++
 tb/tb_miss_burst_controller.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/miss_burst_controller.sv
// Cache miss controller: optional dirty-victim write-back burst, then line refill burst over a valid/ready channel.
// Optional performance counters are enabled by defining MISS_BURST_PERF_CNT_EN.
module miss_burst_controller #(
    parameter int ADDR_W      = 16,
    parameter int WORD_W      = 32,
    parameter int BLOCK_WORDS = 8,
    localparam int BLOCK_W    = BLOCK_WORDS * WORD_W,
    localparam int OFF_W      = $clog2(BLOCK_W / 8),
    localparam int BEAT_W     = $clog2(BLOCK_WORDS)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               miss_valid,
    input  logic [ADDR_W-1:0]  miss_addr,
    input  logic               wb_needed,
    input  logic [ADDR_W-1:0]  wb_addr,
    input  logic [BLOCK_W-1:0] wb_block,
    output logic               busy,
    output logic               refill_valid,
    output logic [BLOCK_W-1:0] refill_block,
    output logic               mem_req_valid,
    input  logic               mem_req_ready,
    output logic               mem_req_we,
    output logic [ADDR_W-1:0]  mem_req_addr,
    output logic [WORD_W-1:0]  mem_req_wdata,
`ifdef MISS_BURST_PERF_CNT_EN
    output logic [31:0]        perf_miss_cnt,
    output logic [31:0]        perf_wb_cnt,
`endif
    input  logic               mem_rvalid,
    input  logic [WORD_W-1:0]  mem_rdata
);

    localparam int BYTE_W = $clog2(WORD_W / 8);

    typedef logic [BEAT_W:0]   cnt_t;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef enum logic [1:0] {IDLE, WB, RD, DONE} state_t;

    localparam cnt_t  CNT_FULL = cnt_t'(BLOCK_WORDS);
    localparam cnt_t  CNT_LAST = cnt_t'(BLOCK_WORDS - 1);
    localparam addr_t OFF_MASK = addr_t'((1 << OFF_W) - 1);

    state_t state, next_state;
    cnt_t   req_cnt, rsp_cnt;
    addr_t  line_base, victim_base, beat_off;
    logic [BLOCK_WORDS-1:0][WORD_W-1:0] victim_words, refill_words;
    logic   miss_take, req_hs, rsp_take;

    assign miss_take    = (state == IDLE) && miss_valid;
    assign req_hs       = mem_req_valid && mem_req_ready;
    assign rsp_take     = (state == RD) && mem_rvalid && (rsp_cnt != CNT_FULL);
    assign beat_off     = addr_t'(req_cnt[BEAT_W-1:0]) << BYTE_W;
    assign refill_block = refill_words;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    // Leave RD on the cycle the final response lands so DONE follows without a bubble.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: if (miss_valid) next_state = wb_needed ? WB : RD;
            WB:   if (req_hs && req_cnt == CNT_LAST) next_state = RD;
            RD:   if (rsp_take && rsp_cnt == CNT_LAST) next_state = DONE;
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Request fields depend only on state and req_cnt, so they cannot move while waiting for ready.
    always_comb begin
        busy          = (state != IDLE);
        refill_valid  = (state == DONE);
        mem_req_valid = 1'b0;
        mem_req_we    = 1'b0;
        mem_req_addr  = '0;
        mem_req_wdata = '0;
        unique case (state)
            WB: if (req_cnt != CNT_FULL) begin
                mem_req_valid = 1'b1;
                mem_req_we    = 1'b1;
                mem_req_addr  = victim_base | beat_off;
                mem_req_wdata = victim_words[req_cnt[BEAT_W-1:0]];
            end
            RD: if (req_cnt != CNT_FULL) begin
                mem_req_valid = 1'b1;
                mem_req_addr  = line_base | beat_off;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_cnt      <= '0;
            rsp_cnt      <= '0;
            line_base    <= '0;
            victim_base  <= '0;
            victim_words <= '0;
            refill_words <= '0;
        end else begin
            if (miss_take) begin
                line_base    <= miss_addr & ~OFF_MASK;
                victim_base  <= wb_addr & ~OFF_MASK;
                victim_words <= wb_block;
                req_cnt      <= '0;
                rsp_cnt      <= '0;
            end else if (req_hs) begin
                if (state == WB && req_cnt == CNT_LAST) req_cnt <= '0;
                else                                     req_cnt <= req_cnt + 1'b1;
            end
            if (rsp_take) begin
                refill_words[rsp_cnt[BEAT_W-1:0]] <= mem_rdata;
                rsp_cnt                           <= rsp_cnt + 1'b1;
            end
        end
    end

`ifdef MISS_BURST_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_miss_cnt <= '0;
            perf_wb_cnt   <= '0;
        end else if (miss_take) begin
            if (perf_miss_cnt != '1)              perf_miss_cnt <= perf_miss_cnt + 1'b1;
            if (wb_needed && perf_wb_cnt != '1)   perf_wb_cnt   <= perf_wb_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_miss_burst_controller.sv
// Bench for miss_burst_controller: table of misses against a memory model with a request scoreboard.
// Also covers stray responses, mid-burst reset and (with MISS_BURST_PERF_CNT_EN) the perf counters.
module tb_miss_burst_controller;

    localparam int ADDR_W      = 16;
    localparam int WORD_W      = 32;
    localparam int BLOCK_WORDS = 8;
    localparam int BLOCK_W     = BLOCK_WORDS * WORD_W;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               miss_valid = 1'b0;
    logic [ADDR_W-1:0]  miss_addr = '0;
    logic               wb_needed = 1'b0;
    logic [ADDR_W-1:0]  wb_addr = '0;
    logic [BLOCK_W-1:0] wb_block = '0;
    logic               busy, refill_valid, mem_req_valid, mem_req_we;
    logic [BLOCK_W-1:0] refill_block;
    logic               mem_req_ready = 1'b0;
    logic [ADDR_W-1:0]  mem_req_addr;
    logic [WORD_W-1:0]  mem_req_wdata;
    logic               mem_rvalid = 1'b0;
    logic [WORD_W-1:0]  mem_rdata = '0;
`ifdef MISS_BURST_PERF_CNT_EN
    logic [31:0]        perf_miss_cnt, perf_wb_cnt;
`endif

    always #5 clk = ~clk;

    miss_burst_controller dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .miss_valid    (miss_valid),
        .miss_addr     (miss_addr),
        .wb_needed     (wb_needed),
        .wb_addr       (wb_addr),
        .wb_block      (wb_block),
        .busy          (busy),
        .refill_valid  (refill_valid),
        .refill_block  (refill_block),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_we    (mem_req_we),
        .mem_req_addr  (mem_req_addr),
        .mem_req_wdata (mem_req_wdata),
`ifdef MISS_BURST_PERF_CNT_EN
        .perf_miss_cnt (perf_miss_cnt),
        .perf_wb_cnt   (perf_wb_cnt),
`endif
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata)
    );

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [WORD_W-1:0] wdata;
    } req_t;

    typedef struct {
        int                due;
        logic [WORD_W-1:0] data;
    } rsp_t;

    typedef struct {
        logic [ADDR_W-1:0]  miss_addr;
        logic               wb;
        logic [ADDR_W-1:0]  wb_addr;
        logic [BLOCK_W-1:0] wb_block;
        bit                 rnd_ready;
        int                 lat;
        bit                 stray;
        int                 exp_cycle;
    } vec_t;

    req_t exp_q[$];
    rsp_t rsp_q[$];
    vec_t vecs[6];

    int tests = 0, fails = 0;
    int cyc = 0, lat = 1, hs_wb = 0, hs_rd = 0, rd_idx = 0, pulses = 0, refill_cyc = 0;
    int exp_miss = 0, exp_wb = 0;
    bit ready_rand = 0, stray_en = 0, extra_rsp = 0;
    logic [7:0]         salt = 8'h00;
    logic [BLOCK_W-1:0] exp_block = '0, got_block = '0;
    bit                 hold_pend = 0;
    logic [ADDR_W-1:0]  hold_addr;
    logic               hold_we;
    logic [WORD_W-1:0]  hold_wdata;

    task automatic checkOutput(input string name, input logic [BLOCK_W-1:0] act,
                               input logic [BLOCK_W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock of memory model and monitor, working from the falling edge.
    task automatic tick();
        req_t r;
        rsp_t s;
        @(negedge clk);
        cyc++;
        mem_req_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        mem_rvalid    = 1'b0;
        mem_rdata     = '0;
        if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
            s          = rsp_q.pop_front();
            mem_rvalid = 1'b1;
            mem_rdata  = s.data;
        end else if (stray_en && (!busy || (mem_req_valid && mem_req_we))) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 32'hDEAD_BEEF;
        end
        #1;
        if (hold_pend)
            checkOutput("req_stable", {mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata},
                        {1'b1, hold_addr, hold_we, hold_wdata});
        hold_pend  = mem_req_valid && !mem_req_ready;
        hold_addr  = mem_req_addr;
        hold_we    = mem_req_we;
        hold_wdata = mem_req_wdata;
        if (mem_req_valid && mem_req_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL unexpected_req: got addr %0h we %0b expected none",
                         mem_req_addr, mem_req_we);
            end else begin
                r = exp_q.pop_front();
                if (r.we) begin
                    checkOutput("wr_beat", {mem_req_addr, mem_req_we, mem_req_wdata},
                                {r.addr, 1'b1, r.wdata});
                    hs_wb++;
                end else begin
                    checkOutput("rd_beat", {mem_req_addr, mem_req_we}, {r.addr, 1'b0});
                    s.due  = cyc + lat;
                    s.data = {8'hA5, salt, r.addr};
                    rsp_q.push_back(s);
                    exp_block[rd_idx*WORD_W +: WORD_W] = s.data;
                    rd_idx++;
                    hs_rd++;
                    if (extra_rsp && rd_idx == BLOCK_WORDS) begin
                        s.due  = cyc + lat + 1;
                        s.data = 32'hBAD0_0009;
                        rsp_q.push_back(s);
                    end
                end
            end
        end
        if (refill_valid) begin
            pulses++;
            refill_cyc = cyc;
            got_block  = refill_block;
            miss_valid = 1'b0;
        end
    endtask

    // Drive one miss, queue its expected beats, and check the refill that comes back.
    task automatic applyStimulus(input vec_t v);
        logic [ADDR_W-1:0] lb, vb;
        int start;
        lb = {v.miss_addr[ADDR_W-1:5], 5'b0};
        vb = {v.wb_addr[ADDR_W-1:5], 5'b0};
        rd_idx = 0; hs_wb = 0; hs_rd = 0; pulses = 0;
        exp_block = '0;
        salt++;
        ready_rand = v.rnd_ready;
        lat        = v.lat;
        stray_en   = v.stray;
        extra_rsp  = v.stray;
        if (v.wb)
            for (int i = 0; i < BLOCK_WORDS; i++)
                exp_q.push_back('{vb + ADDR_W'(i * 4), 1'b1, v.wb_block[i*WORD_W +: WORD_W]});
        for (int i = 0; i < BLOCK_WORDS; i++)
            exp_q.push_back('{lb + ADDR_W'(i * 4), 1'b0, '0});
        if (v.stray) begin
            tick();
            tick();
        end
        miss_addr  = v.miss_addr;
        wb_needed  = v.wb;
        wb_addr    = v.wb_addr;
        wb_block   = v.wb_block;
        miss_valid = 1'b1;
        start      = cyc;
        exp_miss++;
        if (v.wb) exp_wb++;
        for (int k = 0; k < 600 && pulses == 0; k++) tick();
        if (pulses == 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL refill_timeout: got no refill_valid expected one");
            miss_valid = 1'b0;
        end
        if (v.exp_cycle != 0) checkOutput("latency", refill_cyc - start, v.exp_cycle);
        checkOutput("refill_block", got_block, exp_block);
        tick();
        checkOutput("busy_after", busy, 0);
        for (int k = 0; k < 50 && rsp_q.size() > 0; k++) tick();
        tick();
        tick();
        checkOutput("single_pulse", pulses, 1);
        checkOutput("block_hold", refill_block, exp_block);
        checkOutput("wb_beats", hs_wb, v.wb ? BLOCK_WORDS : 0);
        checkOutput("rd_beats", hs_rd, BLOCK_WORDS);
        checkOutput("req_queue_empty", exp_q.size(), 0);
        stray_en  = 0;
        extra_rsp = 0;
    endtask

    initial begin
        logic [BLOCK_W-1:0] pat, wsum;
        for (int i = 0; i < BLOCK_WORDS; i++) begin
            wsum[i*WORD_W +: WORD_W] = WORD_W'(i) * 32'h1111_1111;
            pat[i*WORD_W +: WORD_W]  = 32'hC0DE_0000 + WORD_W'(i * 3);
        end
        vecs[0] = '{16'h1234, 1'b0, 16'h0000, '0,   0, 1, 0, 10};
        vecs[1] = '{16'h2000, 1'b1, 16'h0840, wsum, 0, 1, 0, 18};
        vecs[2] = '{16'h3F7C, 1'b1, 16'hA5A0, pat,  1, 5, 0, 0};
        vecs[3] = '{16'hFFE4, 1'b0, 16'h0000, '0,   1, 5, 0, 0};
        vecs[4] = '{16'h4444, 1'b1, 16'h7770, ~pat, 0, 1, 1, 18};
        vecs[5] = '{16'h9A9F, 1'b0, 16'h0000, '0,   1, 3, 1, 0};

        tick();
        tick();
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_refill_valid", refill_valid, 0);
        checkOutput("reset_req", {mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata}, '0);
        checkOutput("reset_block", refill_block, '0);
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

        // Reset in the middle of a write-back burst, then a fresh clean miss.
        salt++;
        ready_rand = 0;
        lat        = 1;
        hs_wb = 0; hs_rd = 0; rd_idx = 0;
        for (int i = 0; i < BLOCK_WORDS; i++)
            exp_q.push_back('{16'h5560 + ADDR_W'(i * 4), 1'b1, pat[i*WORD_W +: WORD_W]});
        miss_addr  = 16'h6600;
        wb_needed  = 1'b1;
        wb_addr    = 16'h5560;
        wb_block   = pat;
        miss_valid = 1'b1;
        for (int k = 0; k < 50 && hs_wb < 3; k++) tick();
        @(posedge clk);
        #2;
        checkOutput("valid_before_reset", {mem_req_valid, busy}, 2'b11);
        reset_n = 1'b0;
        #1;
        checkOutput("async_reset_valid", mem_req_valid, 0);
        checkOutput("async_reset_busy", busy, 0);
        miss_valid = 1'b0;
        wb_needed  = 1'b0;
        exp_q.delete();
        rsp_q.delete();
        hold_pend = 0;
        exp_miss  = 0;
        exp_wb    = 0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        applyStimulus('{16'h7B2C, 1'b0, 16'h0000, '0, 0, 1, 0, 10});

`ifdef MISS_BURST_PERF_CNT_EN
        applyStimulus(vecs[0]);
        applyStimulus(vecs[1]);
        checkOutput("perf_miss_cnt", perf_miss_cnt, exp_miss);
        checkOutput("perf_wb_cnt", perf_wb_cnt, exp_wb);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
